demuxb4_gather: RTL

Registered 1-to-4 inverting demultiplexer and word assembler: the receive-side counterpart of the inverting 4:1 mux cell (Z = ~A[SL]). It accepts one complemented data beat per handshake on a shared bus plus a 2-bit lane select, restores true polarity, and steers the beat into one of four lane registers. Once all four lanes are filled, it presents the assembled word downstream through a valid/ready handshake. It sits after the mux-based lane-sharing datapath in the std-cell test structures and rebuilds the original four-lane word.

---
 rtl/demuxb4_pkg.sv | 11 +
 rtl/demuxb4_lane.sv | 14 +
 rtl/demuxb4_gather.sv | 56 +++++
 3 files changed

// File: rtl/demuxb4_pkg.sv
// demuxb4_pkg: shared constants, FSM state and lane helpers for demuxb4_gather
package demuxb4_pkg;
   localparam int LANES = 4;
   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;
   function automatic logic [1:0] lane_idx(input logic [1:0] sl);
      return {sl[1], sl[0]};
   endfunction
   function automatic logic [LANES-1:0] lane_oh(input logic [1:0] lane);
      return LANES'(1) << lane;
   endfunction
endpackage

// File: rtl/demuxb4_lane.sv
// demuxb4_lane: one lane register with write enable and optional polarity restore
module demuxb4_lane #(
   parameter int WIDTH = 1,
   parameter int INV = 1
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge CK)
      q <= RST ? '0 : we ? ((INV != 0) ? ~d : d) : q;
endmodule

// File: rtl/demuxb4_gather.sv
// demuxb4_gather: inverting 1:4 demux that gathers four lane beats into one word
module demuxb4_gather
   import demuxb4_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int INV = 1
) (
   input  logic                   CK,
   input  logic                   RST,
   input  logic [WIDTH-1:0]       D,
   input  logic [1:0]             SL,
   input  logic                   IVLD,
   output logic                   IRDY,
   output logic [LANES*WIDTH-1:0] Q,
   output logic                   OVLD,
   input  logic                   ORDY,
   output logic [LANES-1:0]       FILL,
   output logic                   ERR
);
   state_t state;
   logic [1:0] lane;
   logic [LANES-1:0] oh, fill_n;
   logic acc;
   assign lane = lane_idx(SL);
   assign oh = lane_oh(lane);
   assign IRDY = (state == COLLECT) || ORDY;
   assign acc = IVLD && IRDY;
   assign fill_n = FILL | oh;
   assign OVLD = (state == FULL);
   always_ff @(posedge CK) begin
      if (RST) begin
         state <= COLLECT;
         FILL <= '0;
         ERR <= 1'b0;
      end else if (state == COLLECT) begin
         if (acc) begin
            FILL <= fill_n;
            ERR <= ERR | FILL[lane];
            state <= (fill_n == '1) ? FULL : COLLECT;
         end
      end else if (ORDY) begin
         // a beat accepted while draining starts the next word
         FILL <= acc ? oh : '0;
         state <= COLLECT;
      end
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      demuxb4_lane #(.WIDTH(WIDTH), .INV(INV)) u_lane (
         .CK(CK),
         .RST(RST),
         .we(acc && (lane == 2'(i))),
         .d(D),
         .q(Q[i*WIDTH +: WIDTH])
      );
   end
endmodule
